// File: rtl/arc4_crack_sched.sv
// -----------------------------------------------------------------------------
// arc4_crack_sched
//
// Per-core scheduler for the ARC4 key-search datapath. For each candidate key
// it runs the init, ksa and prga sub-blocks one after another through their
// en/rdy handshakes. While a sub-block runs, it owns the single shared
// 256x8 S-memory port. After a failed verdict the key advances by STRIDE.
// The search ends on a match, on key-space exhaustion, or on an external stop.
//
// Optional build macro:
//   ARC4_CRACK_TRIES_EN  when defined, tries_o counts evaluated non-matching
//                        candidates (saturating). When undefined, tries_o is
//                        tied to zero and no counter is built.
//
// Parameters:
//   STRIDE   key increment between candidates (core count in parallel builds)
//   KEY_MAX  last key that may be tried
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   en_i / rdy_o          start request / idle indicator (en accepted when rdy)
//   key_start_i           first candidate key, sampled with an accepted en_i
//   stop_i                abort request from a sibling core (hold until rdy_o)
//   key_o, key_valid_o    current/final key; 1 = key_o holds the match
//   {init,ksa,prga}_en_o  one-cycle start pulses to the sub-blocks
//   {init,ksa,prga}_rdy_i sub-block idle/done
//   prga_ok_i             prga verdict, valid when prga_rdy_i returns high
//   {init,ksa,prga}_addr_i/_wrdata_i/_wren_i   requester memory signals
//   s_addr_o, s_wrdata_o, s_wren_o             shared S-memory port
//   s_rddata_i            S-memory read data (routed to requesters externally)
//   tries_o               number of candidates evaluated without a match
// -----------------------------------------------------------------------------
module arc4_crack_sched #(
    parameter logic [23:0] STRIDE  = 24'd1,
    parameter logic [23:0] KEY_MAX = 24'hFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    output logic        rdy_o,
    input  logic [23:0] key_start_i,
    input  logic        stop_i,
    output logic [23:0] key_o,
    output logic        key_valid_o,
    output logic        init_en_o,
    output logic        ksa_en_o,
    output logic        prga_en_o,
    input  logic        init_rdy_i,
    input  logic        ksa_rdy_i,
    input  logic        prga_rdy_i,
    input  logic        prga_ok_i,
    input  logic [7:0]  init_addr_i,
    input  logic [7:0]  ksa_addr_i,
    input  logic [7:0]  prga_addr_i,
    input  logic [7:0]  init_wrdata_i,
    input  logic [7:0]  ksa_wrdata_i,
    input  logic [7:0]  prga_wrdata_i,
    input  logic        init_wren_i,
    input  logic        ksa_wren_i,
    input  logic        prga_wren_i,
    output logic [7:0]  s_addr_o,
    output logic [7:0]  s_wrdata_o,
    output logic        s_wren_o,
    input  logic [7:0]  s_rddata_i,
    output logic [23:0] tries_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT_GO   = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_KSA_GO    = 3'd3,
        ST_KSA_WAIT  = 3'd4,
        ST_PRGA_GO   = 3'd5,
        ST_PRGA_WAIT = 3'd6,
        ST_NEXT      = 3'd7
    } state_t;

    state_t      state_q,     state_d;
    logic [23:0] key_q,       key_d;
    logic        key_valid_q, key_valid_d;
    logic        rdy_q,       rdy_d;
    logic        first_q,     first_d;     // first cycle of an X_WAIT state
    logic        init_en_q,   init_en_d;
    logic        ksa_en_q,    ksa_en_d;
    logic        prga_en_q,   prga_en_d;

    // 25-bit sum so that stepping past 24'hFFFFFF counts as exhaustion
    // instead of wrapping back to a low key.
    logic [24:0] key_sum_s;
    logic        last_key_s;

    // Read data goes straight from the memory to the requesters outside this
    // block; it is reduced here only so the port has a load.
    logic        unused_rddata_s;

    assign key_sum_s       = {1'b0, key_q} + {1'b0, STRIDE};
    assign last_key_s      = stop_i || (key_sum_s > {1'b0, KEY_MAX});
    assign unused_rddata_s = ^s_rddata_i;

    // Next-state and next-output logic of the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        rdy_d       = rdy_q;
        first_d     = first_q;
        init_en_d   = 1'b0;
        ksa_en_d    = 1'b0;
        prga_en_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    key_d       = key_start_i;
                    key_valid_d = 1'b0;
                    rdy_d       = 1'b0;
                    init_en_d   = 1'b1;
                    state_d     = ST_INIT_GO;
                end else begin
                    rdy_d = 1'b1;
                end
            end
            ST_INIT_GO: begin
                first_d = 1'b1;
                state_d = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                // Sub-blocks drop rdy one cycle after en, so the first
                // WAIT cycle still shows the stale idle level.
                if (first_q) begin
                    first_d = 1'b0;
                end else if (init_rdy_i) begin
                    ksa_en_d = 1'b1;
                    state_d  = ST_KSA_GO;
                end else begin
                    state_d = ST_INIT_WAIT;
                end
            end
            ST_KSA_GO: begin
                first_d = 1'b1;
                state_d = ST_KSA_WAIT;
            end
            ST_KSA_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (ksa_rdy_i) begin
                    prga_en_d = 1'b1;
                    state_d   = ST_PRGA_GO;
                end else begin
                    state_d = ST_KSA_WAIT;
                end
            end
            ST_PRGA_GO: begin
                first_d = 1'b1;
                state_d = ST_PRGA_WAIT;
            end
            ST_PRGA_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (prga_rdy_i) begin
                    if (prga_ok_i) begin
                        key_valid_d = 1'b1;
                        rdy_d       = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else begin
                    state_d = ST_PRGA_WAIT;
                end
            end
            ST_NEXT: begin
                // On stop or exhaustion key_q keeps the last key tried.
                if (last_key_s) begin
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    key_d     = key_sum_s[23:0];
                    init_en_d = 1'b1;
                    state_d   = ST_INIT_GO;
                end
            end
            default: begin
                rdy_d   = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ARC4_CRACK_TRIES_EN
    logic [23:0] tries_q, tries_d;

    // Saturating count of NEXT visits, cleared when a new search starts.
    always_comb begin
        if ((state_q == ST_IDLE) && en_i) begin
            tries_d = 24'd0;
        end else if ((state_q == ST_NEXT) && (tries_q != 24'hFF_FFFF)) begin
            tries_d = tries_q + 24'd1;
        end else begin
            tries_d = tries_q;
        end
    end

    assign tries_o = tries_q;
`else
    assign tries_o = 24'd0;
`endif

    // Scheduler state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            key_q       <= 24'd0;
            key_valid_q <= 1'b0;
            rdy_q       <= 1'b1;
            first_q     <= 1'b0;
            init_en_q   <= 1'b0;
            ksa_en_q    <= 1'b0;
            prga_en_q   <= 1'b0;
`ifdef ARC4_CRACK_TRIES_EN
            tries_q     <= 24'd0;
`endif
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            rdy_q       <= rdy_d;
            first_q     <= first_d;
            init_en_q   <= init_en_d;
            ksa_en_q    <= ksa_en_d;
            prga_en_q   <= prga_en_d;
`ifdef ARC4_CRACK_TRIES_EN
            tries_q     <= tries_d;
`endif
        end
    end

    // Shared S-memory port: the sub-block whose GO/WAIT state is active owns
    // it; everything else, including writes from non-owners, is dropped.
    always_comb begin
        s_addr_o   = 8'd0;
        s_wrdata_o = 8'd0;
        s_wren_o   = 1'b0;
        case (state_q)
            ST_INIT_GO, ST_INIT_WAIT: begin
                s_addr_o   = init_addr_i;
                s_wrdata_o = init_wrdata_i;
                s_wren_o   = init_wren_i;
            end
            ST_KSA_GO, ST_KSA_WAIT: begin
                s_addr_o   = ksa_addr_i;
                s_wrdata_o = ksa_wrdata_i;
                s_wren_o   = ksa_wren_i;
            end
            ST_PRGA_GO, ST_PRGA_WAIT: begin
                s_addr_o   = prga_addr_i;
                s_wrdata_o = prga_wrdata_i;
                s_wren_o   = prga_wren_i;
            end
            default: begin
                s_addr_o   = 8'd0;
                s_wrdata_o = 8'd0;
                s_wren_o   = 1'b0;
            end
        endcase
    end

    assign rdy_o       = rdy_q;
    assign key_o       = key_q;
    assign key_valid_o = key_valid_q;
    assign init_en_o   = init_en_q;
    assign ksa_en_o    = ksa_en_q;
    assign prga_en_o   = prga_en_q;

endmodule

// File: tb/tb_arc4_crack_sched.sv
// -----------------------------------------------------------------------------
// tb_arc4_crack_sched
//
// Two scheduler instances: core 0 with STRIDE=1/KEY_MAX=24'hFFFFFF and core 1
// with STRIDE=4/KEY_MAX=24'h000009. Stub sub-blocks answer each en pulse with
// a random busy time and write continuously at a per-requester address. The
// expected key sequence, verdict and try count of every search come from a
// plain loop over the search rules; handshake order and memory ownership are
// inferred from the observed en/rdy protocol.
// -----------------------------------------------------------------------------
module tb_arc4_crack_sched;

    localparam logic [23:0] C0_STRIDE = 24'd1;
    localparam logic [23:0] C0_MAX    = 24'hFF_FFFF;
    localparam logic [23:0] C1_STRIDE = 24'd4;
    localparam logic [23:0] C1_MAX    = 24'h00_0009;

    logic        clk;
    logic        rst_n;
    logic        en          [2];
    logic [23:0] key_start   [2];
    logic        stop        [2];
    logic        rdy         [2];
    logic [23:0] key         [2];
    logic        key_valid   [2];
    logic [23:0] tries       [2];
    logic        init_en     [2];
    logic        ksa_en      [2];
    logic        prga_en     [2];
    logic [2:0]  sub_en      [2];
    logic [2:0]  sub_rdy     [2];
    int unsigned lat_cnt     [2][3];
    logic        prga_ok     [2];
    logic        match_on    [2];
    logic [23:0] match_key   [2];
    logic [7:0]  req_addr    [2][3];
    logic [7:0]  req_wrdata  [2][3];
    logic [7:0]  s_addr      [2];
    logic [7:0]  s_wrdata    [2];
    logic        s_wren      [2];
    logic [7:0]  s_rddata;

    int          n_checks;
    int          n_fail;

    // Protocol tracking used by the handshake and ownership checks.
    int          phase       [2];
    int          last_j      [2];
    bit          was_busy    [2];
    logic [23:0] init_key    [2];
    logic [23:0] tried[$];

    function automatic logic [7:0] addr_of(input int c, input int j);
        return 8'((j + 1) * 64 + c);
    endfunction

    function automatic longint stride_of(input int c);
        return (c == 0) ? longint'(C0_STRIDE) : longint'(C1_STRIDE);
    endfunction

    function automatic longint kmax_of(input int c);
        return (c == 0) ? longint'(C0_MAX) : longint'(C1_MAX);
    endfunction

    arc4_crack_sched #(.STRIDE(C0_STRIDE), .KEY_MAX(C0_MAX)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en_i(en[0]), .rdy_o(rdy[0]),
        .key_start_i(key_start[0]), .stop_i(stop[0]), .key_o(key[0]),
        .key_valid_o(key_valid[0]),
        .init_en_o(init_en[0]), .ksa_en_o(ksa_en[0]), .prga_en_o(prga_en[0]),
        .init_rdy_i(sub_rdy[0][0]), .ksa_rdy_i(sub_rdy[0][1]), .prga_rdy_i(sub_rdy[0][2]),
        .prga_ok_i(prga_ok[0]),
        .init_addr_i(req_addr[0][0]), .ksa_addr_i(req_addr[0][1]), .prga_addr_i(req_addr[0][2]),
        .init_wrdata_i(req_wrdata[0][0]), .ksa_wrdata_i(req_wrdata[0][1]),
        .prga_wrdata_i(req_wrdata[0][2]),
        .init_wren_i(1'b1), .ksa_wren_i(1'b1), .prga_wren_i(1'b1),
        .s_addr_o(s_addr[0]), .s_wrdata_o(s_wrdata[0]), .s_wren_o(s_wren[0]),
        .s_rddata_i(s_rddata), .tries_o(tries[0])
    );

    arc4_crack_sched #(.STRIDE(C1_STRIDE), .KEY_MAX(C1_MAX)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en_i(en[1]), .rdy_o(rdy[1]),
        .key_start_i(key_start[1]), .stop_i(stop[1]), .key_o(key[1]),
        .key_valid_o(key_valid[1]),
        .init_en_o(init_en[1]), .ksa_en_o(ksa_en[1]), .prga_en_o(prga_en[1]),
        .init_rdy_i(sub_rdy[1][0]), .ksa_rdy_i(sub_rdy[1][1]), .prga_rdy_i(sub_rdy[1][2]),
        .prga_ok_i(prga_ok[1]),
        .init_addr_i(req_addr[1][0]), .ksa_addr_i(req_addr[1][1]), .prga_addr_i(req_addr[1][2]),
        .init_wrdata_i(req_wrdata[1][0]), .ksa_wrdata_i(req_wrdata[1][1]),
        .prga_wrdata_i(req_wrdata[1][2]),
        .init_wren_i(1'b1), .ksa_wren_i(1'b1), .prga_wren_i(1'b1),
        .s_addr_o(s_addr[1]), .s_wrdata_o(s_wrdata[1]), .s_wren_o(s_wren[1]),
        .s_rddata_i(s_rddata), .tries_o(tries[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub wiring: en vectors, requester constants, prga verdict.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            sub_en[c]  = {prga_en[c], ksa_en[c], init_en[c]};
            prga_ok[c] = match_on[c] && (key[c] == match_key[c]);
            for (int j = 0; j < 3; j++) begin
                req_addr[c][j]   = addr_of(c, j);
                req_wrdata[c][j] = ~addr_of(c, j);
            end
        end
    end

    // Stub sub-blocks: drop rdy the cycle after en, stay busy 1..4 cycles.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < 3; j++) begin
                if (!rst_n) begin
                    sub_rdy[c][j] <= 1'b1;
                    lat_cnt[c][j] <= 0;
                end else if (sub_en[c][j] && sub_rdy[c][j]) begin
                    sub_rdy[c][j] <= 1'b0;
                    lat_cnt[c][j] <= $urandom_range(0, 3);
                end else if (!sub_rdy[c][j]) begin
                    if (lat_cnt[c][j] == 0) sub_rdy[c][j] <= 1'b1;
                    else lat_cnt[c][j] <= lat_cnt[c][j] - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_tracking();
        for (int c = 0; c < 2; c++) begin
            phase[c]    = 0;
            last_j[c]   = -1;
            was_busy[c] = 1'b0;
            init_key[c] = 24'd0;
        end
        tried.delete();
    endtask

    // Per-cycle protocol and memory ownership checks for one core.
    task automatic check_cycle(input int c);
        int         owner;
        logic [7:0] ea;
        logic [7:0] ed;
        logic       ew;
        owner = -1;
        chk("hs_onehot", 64'($countones(sub_en[c]) > 1), 64'd0);
        for (int j = 0; j < 3; j++) begin
            if (sub_en[c][j]) begin
                owner = j;
                chk("hs_order", 64'(phase[c]), 64'(j));
                chk("hs_en_while_busy", 64'(sub_rdy[c][j]), 64'd1);
                if (j == 0) begin
                    init_key[c] = key[c];
                    tried.push_back(key[c]);
                end else begin
                    chk("key_stable", 64'(key[c]), 64'(init_key[c]));
                end
                phase[c]    = (j + 1) % 3;
                last_j[c]   = j;
                was_busy[c] = 1'b0;
            end
        end
        if (owner < 0 && last_j[c] >= 0) begin
            if (!sub_rdy[c][last_j[c]]) begin
                owner       = last_j[c];
                was_busy[c] = 1'b1;
            end else if (was_busy[c]) begin
                // cycle in which the scheduler sees the sub-block done
                owner       = last_j[c];
                was_busy[c] = 1'b0;
                last_j[c]   = -1;
            end
        end
        ea = (owner >= 0) ? addr_of(c, owner) : 8'd0;
        ed = (owner >= 0) ? ~addr_of(c, owner) : 8'd0;
        ew = (owner >= 0);
        chk("mux", 64'({s_addr[c], s_wrdata[c], s_wren[c]}), 64'({ea, ed, ew}));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) begin
            check_cycle(0);
            check_cycle(1);
        end
    endtask

    task automatic check_reset(input int c);
        chk("rst_rdy", 64'(rdy[c]), 64'd1);
        chk("rst_en", 64'(sub_en[c]), 64'd0);
        chk("rst_mem", 64'({s_addr[c], s_wrdata[c], s_wren[c]}), 64'd0);
        chk("rst_key", 64'(key[c]), 64'd0);
        chk("rst_key_valid", 64'(key_valid[c]), 64'd0);
        chk("rst_tries", 64'(tries[c]), 64'd0);
    endtask

    // One search; stop_idx >= 0 raises stop during the ksa run of that key.
    task automatic run(input int c, input logic [23:0] start, input bit mon,
                       input logic [23:0] mk, input int stop_idx, input string tag);
        logic [23:0] exp_q[$];
        longint      k;
        int          nt;
        bit          ev;
        int          cyc;
        k  = longint'(start);
        nt = 0;
        ev = 1'b0;
        while (1) begin
            exp_q.push_back(24'(k));
            if (mon && (24'(k) == mk)) begin
                ev = 1'b1;
                break;
            end
            nt++;
            if (stop_idx >= 0 && exp_q.size() > stop_idx) break;
            if (k + stride_of(c) > kmax_of(c)) break;
            k = k + stride_of(c);
        end

        tried.delete();
        match_on[c]  = mon;
        match_key[c] = mk;
        key_start[c] = start;
        en[c]        = 1'b1;
        step();
        en[c]        = 1'b0;
        key_start[c] = 24'd0;
        chk({tag, "_busy"}, 64'(rdy[c]), 64'd0);
        cyc = 0;
        while (rdy[c] == 1'b0 && cyc < 4000) begin
            // en while busy must be ignored
            en[c]        = (cyc == 3);
            key_start[c] = (cyc == 3) ? 24'h5A_5A5A : 24'd0;
            step();
            cyc++;
            if (stop_idx >= 0 && ksa_en[c] && tried.size() == stop_idx + 1) stop[c] = 1'b1;
        end
        en[c]        = 1'b0;
        key_start[c] = 24'd0;
        stop[c]      = 1'b0;
        chk({tag, "_timeout"}, 64'(cyc < 4000), 64'd1);
        chk({tag, "_ntried"}, 64'(tried.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < tried.size()) chk({tag, "_key_seq"}, 64'(tried[i]), 64'(exp_q[i]));
        end
        chk({tag, "_key"}, 64'(key[c]), 64'(exp_q[exp_q.size() - 1]));
        chk({tag, "_key_valid"}, 64'(key_valid[c]), 64'(ev));
`ifdef ARC4_CRACK_TRIES_EN
        chk({tag, "_tries"}, 64'(tries[c]), 64'(nt));
`else
        chk({tag, "_tries"}, 64'(tries[c]), 64'd0);
`endif
        chk({tag, "_hs_complete"}, 64'(phase[c]), 64'd0);
        step();
        step();
    endtask

    initial begin
        int          cyc;
        logic [23:0] rs;
        int          off;
        n_checks = 0;
        n_fail   = 0;
        s_rddata = 8'h5C;
        rst_n    = 1'b0;
        for (int c = 0; c < 2; c++) begin
            en[c]        = 1'b0;
            key_start[c] = 24'd0;
            stop[c]      = 1'b0;
            match_on[c]  = 1'b0;
            match_key[c] = 24'd0;
        end
        reset_tracking();
        step();
        step();
        check_reset(0);
        check_reset(1);
        rst_n = 1'b1;
        step();

        // Match on the third key.
        run(0, 24'h00_0010, 1'b1, 24'h00_0012, -1, "match3");
        // Exhaustion with STRIDE=4, KEY_MAX=9: keys 2, 6.
        run(1, 24'h00_0002, 1'b0, 24'd0, -1, "exhaust");
        // Stop during ksa of key 5: 9 would be legal but must not be tried.
        run(1, 24'h00_0005, 1'b0, 24'd0, 0, "stop");
        // Single key at the limit.
        run(1, 24'h00_0009, 1'b0, 24'd0, -1, "at_max");
        // Match on the first key: no tries counted.
        run(0, 24'h00_0077, 1'b1, 24'h00_0077, -1, "match1");
        // Top of key space: the 25-bit sum must stop the search.
        run(0, 24'hFF_FFFE, 1'b0, 24'd0, -1, "top");

        // Random searches bounded by a nearby match or stop.
        for (int r = 0; r < 6; r++) begin
            rs  = 24'($urandom_range(0, 32'h00FF_FFF0));
            off = int'($urandom_range(0, 3));
            if (r % 2 == 0) run(0, rs, 1'b1, rs + 24'(off), -1, "rnd_match");
            else            run(0, rs, 1'b0, 24'd0, off, "rnd_stop");
        end

        // Reset while ksa is running.
        key_start[0] = 24'h00_0100;
        match_on[0]  = 1'b0;
        en[0]        = 1'b1;
        step();
        en[0] = 1'b0;
        cyc   = 0;
        while (!ksa_en[0] && cyc < 200) begin
            step();
            cyc++;
        end
        chk("rst_mid_reach_ksa", 64'(cyc < 200), 64'd1);
        step();
        rst_n = 1'b0;
        step();
        check_reset(0);
        rst_n = 1'b1;
        reset_tracking();
        step();
        check_reset(0);
        run(0, 24'h00_0200, 1'b1, 24'h00_0201, -1, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
